// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Package     : debug_pkg
// Description : Shared definitions for the debug link: command bytes, ACK
//               bytes, end-of-program marker and debug FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_pkg;

  // Command bytes received over the UART debug link
  localparam logic [7:0]  c_CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0]  c_CMD_LOAD = 8'h6C;  // 'l'

  // ACK bytes returned at the end of a load session
  localparam logic [7:0]  c_ACK_HALT = 8'h4B;  // 'K': halt word seen
  localparam logic [7:0]  c_ACK_FULL = 8'h46;  // 'F': instruction memory full

  // End-of-program marker
  localparam logic [31:0] c_HALT_WORD = 32'hFFFF_FFFF;

  // Loader FSM state encodings
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_WORD = 3'd1,
    ST_WRITE   = 3'd2,
    ST_ACK     = 3'd3,
    ST_WAIT_TX = 3'd4
  } dbg_state_e;

endpackage : debug_pkg
`default_nettype wire

// File: rtl/uart_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_assembler
// Description : Packs an MSB-first byte stream into NB-bit words.
//               i_clk, i_reset   : clock, synchronous active-high reset
//               i_clear          : restart assembly (word and count cleared)
//               i_byte_valid     : byte strobe
//               i_byte           : incoming byte
//               o_word           : shift register contents
//               o_word_valid     : high on the strobe that completes a word
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_assembler #(
  parameter int NB        = 32,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_byte_valid,
  input  logic [DATA_BITS-1:0] i_byte,
  output logic [NB-1:0]        o_word,
  output logic                 o_word_valid
);

  localparam int c_BYTES = NB / DATA_BITS;
  localparam int c_CW    = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

  logic [NB-1:0]   r_word;
  logic [c_CW-1:0] r_count;

  // Combinational so the caller can register its write strobe on the same
  // edge that shifts in the final byte.
  assign o_word_valid = i_byte_valid && (r_count == c_CW'(c_BYTES - 1));
  assign o_word       = r_word;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_byte_valid) begin
      r_word <= {r_word[NB-DATA_BITS-1:0], i_byte};
      // Wraps to zero after the last byte of a word
      if (r_count == c_CW'(c_BYTES - 1)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + c_CW'(1);
      end
    end
  end

endmodule : uart_word_assembler
`default_nettype wire

// File: rtl/debug_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : debug_program_loader
// Description : Receives a load command over UART, assembles 32-bit words
//               and writes them to instruction memory until the halt word
//               or the last address, then returns an ACK byte.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_uart_rx_ready    : one-cycle strobe per received byte
//   i_uart_rx_data     : received byte
//   i_uart_tx_done     : UART TX finished the current byte
//   o_uart_tx_data     : ACK byte
//   o_uart_tx_ready    : TX request, held until tx_done
//   o_imem_wr_en       : one-cycle IMEM write strobe
//   o_imem_wr_addr     : IMEM word address
//   o_imem_wr_data     : assembled instruction word
//   o_loading          : session active (holds the CPU in reset)
//   o_load_done        : one-cycle pulse when the ACK completes
// Revision    : 1.0 - initial release
// ============================================================================
module debug_program_loader
  import debug_pkg::*;
#(
  parameter int              NB        = 32,
  parameter int              DATA_BITS = 8,
  parameter int              ADDR_BITS = 8,
  parameter logic [7:0]      CMD_LOAD  = c_CMD_LOAD,
  parameter logic [NB-1:0]   HALT_WORD = c_HALT_WORD
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_uart_rx_ready,
  input  logic [DATA_BITS-1:0] i_uart_rx_data,
  input  logic                 i_uart_tx_done,
  output logic [DATA_BITS-1:0] o_uart_tx_data,
  output logic                 o_uart_tx_ready,
  output logic                 o_imem_wr_en,
  output logic [ADDR_BITS-1:0] o_imem_wr_addr,
  output logic [NB-1:0]        o_imem_wr_data,
  output logic                 o_loading,
  output logic                 o_load_done
);

  dbg_state_e             r_state;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DATA_BITS-1:0]   r_ack_byte;
  logic [DATA_BITS-1:0]   r_tx_data;
  logic                   r_tx_ready;
  logic                   r_wr_en;
  logic                   r_loading;
  logic                   r_load_done;

  logic                   w_cmd_accept;
  logic                   w_rx_byte;
  logic [NB-1:0]          w_word;
  logic                   w_word_valid;

  // Bytes are only consumed while collecting a word; anything arriving in
  // WRITE/ACK/WAIT_TX is dropped.
  assign w_cmd_accept = i_uart_rx_ready && (r_state == ST_IDLE) &&
                        (i_uart_rx_data == CMD_LOAD);
  assign w_rx_byte    = i_uart_rx_ready && (r_state == ST_RX_WORD);

  uart_word_assembler #(
    .NB        (NB),
    .DATA_BITS (DATA_BITS)
  ) u_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_cmd_accept),
    .i_byte_valid (w_rx_byte),
    .i_byte       (i_uart_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_ack_byte  <= '0;
      r_tx_data   <= '0;
      r_tx_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_loading   <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_accept) begin
            r_addr    <= '0;
            r_loading <= 1'b1;
            r_state   <= ST_RX_WORD;
          end
        end
        ST_RX_WORD: begin
          if (w_word_valid) begin
            r_wr_en <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The assembler register now holds the completed word
          if (w_word == HALT_WORD) begin
            r_ack_byte <= c_ACK_HALT;
            r_state    <= ST_ACK;
          end else if (r_addr == {ADDR_BITS{1'b1}}) begin
            r_ack_byte <= c_ACK_FULL;
            r_state    <= ST_ACK;
          end else begin
            r_addr  <= r_addr + ADDR_BITS'(1);
            r_state <= ST_RX_WORD;
          end
        end
        ST_ACK: begin
          r_tx_data  <= r_ack_byte;
          r_tx_ready <= 1'b1;
          r_state    <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_uart_tx_done) begin
            r_tx_ready  <= 1'b0;
            r_loading   <= 1'b0;
            r_load_done <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_addr     <= '0;
          r_tx_data  <= '0;
          r_tx_ready <= 1'b0;
          r_loading  <= 1'b0;
        end
      endcase
    end
  end

  assign o_uart_tx_data  = r_tx_data;
  assign o_uart_tx_ready = r_tx_ready;
  assign o_imem_wr_en    = r_wr_en;
  assign o_imem_wr_addr  = r_addr;
  assign o_imem_wr_data  = w_word;
  assign o_loading       = r_loading;
  assign o_load_done     = r_load_done;

endmodule : debug_program_loader
`default_nettype wire

// File: tb/tb_debug_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_program_loader
// Description : Self-checking bench for debug_program_loader. A session-level
//               model predicts IMEM writes and ACK/loading windows from the
//               byte stream; a negedge process compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_program_loader;

  localparam longint c_INF = 64'sh7FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        loading;
  logic        load_done;

  always #5 clk = ~clk;

  debug_program_loader dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_uart_rx_ready (rx_rdy),
    .i_uart_rx_data  (rx_data),
    .i_uart_tx_done  (tx_done),
    .o_uart_tx_data  (tx_data),
    .o_uart_tx_ready (tx_ready),
    .o_imem_wr_en    (wr_en),
    .o_imem_wr_addr  (wr_addr),
    .o_imem_wr_data  (wr_data),
    .o_loading       (loading),
    .o_load_done     (load_done)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- session-level model ----------------
  typedef struct {
    longint      c;
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         q[$];
  int          phase = 0;          // 0 idle, 1 collecting words, 2 awaiting tx_done
  logic [31:0] acc = '0;
  int          nb = 0;
  int          addr = 0;
  logic [7:0]  ack_exp = '0;
  longint      load_from = c_INF, load_until = c_INF;
  longint      tx_from = c_INF, tx_until = c_INF;
  longint      done_cyc = -1;

  // b is sampled by the DUT at the edge ending window n
  task automatic model_byte(input logic [7:0] b, input longint n);
    wr_t w;
    if (phase == 0) begin
      if (b == 8'h6C) begin
        phase = 1; addr = 0; nb = 0; acc = '0;
        load_from = n + 1; load_until = c_INF;
      end
    end else if (phase == 1) begin
      acc = {acc[23:0], b};
      nb++;
      if (nb == 4) begin
        nb = 0;
        w.c = n + 1; w.a = 8'(addr); w.d = acc;
        q.push_back(w);
        if (acc == 32'hFFFF_FFFF || addr == 255) begin
          ack_exp  = (acc == 32'hFFFF_FFFF) ? 8'h4B : 8'h46;
          phase    = 2;
          tx_from  = n + 3;
          tx_until = c_INF;
        end else begin
          addr++;
        end
      end
    end
  endtask

  task automatic model_txdone(input longint n);
    if (phase == 2 && n >= tx_from) begin
      phase = 0;
      tx_until = n + 1; load_until = n + 1; done_cyc = n + 1;
    end
  endtask

  task automatic model_reset(input longint n);
    phase = 0; nb = 0;
    if (load_until > n + 1) load_until = n + 1;
    if (tx_until > n + 1) tx_until = n + 1;
    while (q.size() > 0 && q[q.size()-1].c >= n + 1) q.pop_back();
  endtask

  // ---------------- per-cycle compare ----------------
  bit          chk_en = 0;
  int          nwr = 0;
  logic [7:0]  obs_addr = '0;
  logic [31:0] obs_data = '0;
  logic [7:0]  obs_tx = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_wr, exp_tx;
      while (q.size() > 0 && q[0].c < cyc) begin
        chk("wr_missing", 32'd0, 32'd1);
        void'(q.pop_front());
      end
      exp_wr = (q.size() > 0 && q[0].c == cyc);
      chk("wr_en", wr_en, exp_wr);
      if (wr_en) begin
        nwr++; obs_addr = wr_addr; obs_data = wr_data;
      end
      if (exp_wr) begin
        if (wr_en) begin
          chk("wr_addr", wr_addr, q[0].a);
          chk("wr_data", wr_data, q[0].d);
        end
        void'(q.pop_front());
      end
      exp_tx = (cyc >= tx_from) && (cyc < tx_until);
      chk("tx_ready", tx_ready, exp_tx);
      if (exp_tx && tx_ready) begin
        chk("tx_data", tx_data, ack_exp);
        obs_tx = tx_data;
      end
      chk("loading", loading, (cyc >= load_from) && (cyc < load_until));
      chk("load_done", load_done, cyc == done_cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    model_byte(b, cyc);
    rx_rdy = 1'b1; rx_data = b;
    tick();
    rx_rdy = 1'b0; rx_data = 8'($urandom);
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]);
    send_byte(w[15:8]);  send_byte(w[7:0]);
  endtask

  task automatic pulse_txdone();
    tick();
    model_txdone(cyc);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    model_reset(cyc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Wait for the ACK request, let it sit for dly cycles, then complete it.
  task automatic finish_ack(input int dly, input bit inject);
    int k = 0;
    while (!tx_ready && k < 2000) begin
      tick(); k++;
    end
    if (!tx_ready) begin
      chk("ack_timeout", 32'd0, 32'd1);
      return;
    end
    if (inject) begin
      repeat (dly / 2) tick();
      send_byte(8'h6C);
      repeat (dly / 2) tick();
      chk("t5_tx_ready_held", tx_ready, 1'b1);
      chk("t5_loading_held", loading, 1'b1);
    end else begin
      repeat (dly) tick();
    end
    pulse_txdone();
    repeat (3) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; tx_done = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_loading", loading, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 32'h0);
    rst = 1'b0;
    chk_en = 1;
    tick();

    // 1: two words ending with the halt word
    base = nwr;
    send_byte(8'h6C);
    send_word(32'h0000_002A);
    chk("t1_first_addr", obs_addr, 8'd0);
    chk("t1_first_data", obs_data, 32'h0000_002A);
    send_word(32'hFFFF_FFFF);
    finish_ack(4, 0);
    chk("t1_nwr", nwr - base, 2);
    chk("t1_last_addr", obs_addr, 8'd1);
    chk("t1_last_data", obs_data, 32'hFFFF_FFFF);
    chk("t1_ack", obs_tx, 8'h4B);
    chk("t1_loading_off", loading, 1'b0);

    // 2: non-command bytes in idle
    base = nwr;
    send_byte(8'h78); send_byte(8'h73);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 8'h6B)));
    pulse_txdone();
    chk("t2_nwr", nwr - base, 0);
    chk("t2_loading", loading, 1'b0);

    // 3: fill all 256 addresses
    base = nwr;
    send_byte(8'h6C);
    for (int n = 0; n < 256; n++) send_word(32'(n));
    finish_ack(2, 0);
    chk("t3_nwr", nwr - base, 256);
    chk("t3_last_addr", obs_addr, 8'd255);
    chk("t3_last_data", obs_data, 32'd255);
    chk("t3_ack", obs_tx, 8'h46);

    // 4: reset mid-word discards the partial word
    base = nwr;
    send_byte(8'h6C); send_byte(8'h12); send_byte(8'h34);
    do_reset();
    send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A); send_byte(8'hBC);
    chk("t4_nwr_after_reset", nwr - base, 0);
    chk("t4_loading", loading, 1'b0);
    send_byte(8'h6C);
    send_word(32'h1234_5678);
    chk("t4_addr", obs_addr, 8'd0);
    chk("t4_data", obs_data, 32'h1234_5678);
    send_word(32'hFFFF_FFFF);
    finish_ack(1, 0);

    // 5: long tx_done delay with a command byte during the wait
    send_byte(8'h6C);
    send_word(32'hFFFF_FFFF);
    finish_ack(50, 1);
    chk("t5_ack", obs_tx, 8'h4B);
    chk("t5_idle", loading, 1'b0);

    // 6: command byte value accepted as data
    send_byte(8'h6C);
    send_word(32'h6C6C_6C6C);
    chk("t6_addr", obs_addr, 8'd0);
    chk("t6_data", obs_data, 32'h6C6C_6C6C);
    send_word(32'hFFFF_FFFF);
    finish_ack(3, 0);

    // Randomized sessions, idle noise, stray tx_done and resets
    for (int it = 0; it < 40; it++) begin
      int kind = int'($urandom_range(0, 5));
      if (kind == 0) begin
        repeat ($urandom_range(1, 5)) send_byte(8'($urandom));
        if (phase == 2) finish_ack(int'($urandom_range(0, 5)), 0);
        else if (phase == 1) do_reset();
      end else if (kind == 1) begin
        pulse_txdone();
      end else begin
        send_byte(8'h6C);
        repeat ($urandom_range(0, 6)) begin
          if (phase == 1) send_word(($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom);
        end
        if (phase == 1 && kind == 2) begin
          repeat ($urandom_range(0, 3)) send_byte(8'($urandom));
          do_reset();
        end else begin
          if (phase == 1) send_word(32'hFFFF_FFFF);
          finish_ack(int'($urandom_range(0, 10)), 0);
        end
      end
    end

    repeat (5) tick();
    chk("wr_queue_empty", q.size(), 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_debug_program_loader
`default_nettype wire
